mem_copy_job_ctrl: RTL and testbench
====================================

Name: mem_copy_job_ctrl

Overview:
- Job sequencer for the generic-processing AFU; it sits between the CSR block and the CCI-P/MPF channels.
- On a run pulse it issues one c0 read-line request per source cache line, with flow control from c0 almost-full, an outstanding-read credit limit and read-buffer back-pressure.
- It issues one c1 write-line request per processed line to the destination as result lines become available.
- It counts read and write responses and pulses done when every write is acknowledged.

Parameters:
- CL_ADDR_W, 42, cache-line address width (t_cci_clAddr).
- MAX_RD_OUTSTANDING, 64, maximum in-flight read requests (power of 2, 2..512).
- LEN_W, 64, width of the byte-length input.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- run  in  1  single-cycle start pulse.
- src_cl_addr  in  CL_ADDR_W  first source line.
- dst_cl_addr  in  CL_ADDR_W  first destination line.
- length_bytes  in  LEN_W  job length in bytes.
- c0_alm_full  in  1  c0Tx almost-full.
- rd_req_valid  out  1  read request strobe (registered).
- rd_req_addr  out  CL_ADDR_W  read line address.
- rd_req_mdata  out  16  read tag = line index[15:0].
- rd_rsp_valid  in  1  one read response line received.
- buf_full_n  in  1  read buffer can accept one more line.
- c1_alm_full  in  1  c1Tx almost-full.
- wr_line_avail  in  1  a result line is ready.
- wr_line_pop  out  1  consume result line (combinational, same cycle as the issue decision).
- wr_req_valid  out  1  write request strobe (registered).
- wr_req_addr  out  CL_ADDR_W  write line address.
- wr_rsp_valid  in  1  one write ack received.
- busy  out  1  job in progress.
- done  out  1  one-cycle completion pulse.
- run_ignored  out  1  one-cycle pulse when run arrives while busy.
- lines_total  out  LEN_W-6  line count of the current or last job.

Behaviour:
- Reset values: all outputs 0; all counters 0; state IDLE.
- reset asserted mid-job aborts the job immediately, with no done pulse. In-flight responses arriving after reset are ignored.
- Line count: lines = ceil(length_bytes/64) = (length_bytes>>6) + (|length_bytes[5:0]).
- States: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN on run.
  - On the same edge, latch src, dst and lines; clear rd_issued, rd_outst, wr_issued and wr_acked.
  - If lines==0, go IDLE -> DONE instead.
- Read issue condition: state RUN, rd_issued<lines, !c0_alm_full, rd_outst<MAX_RD_OUTSTANDING, buf_full_n.
  - When the condition is true in cycle t, drive rd_req_valid=1 in cycle t+1 with rd_req_addr = src + rd_issued (mod 2^CL_ADDR_W) and rd_req_mdata = rd_issued[15:0].
  - Increment rd_issued.
  - At most one read per cycle.
- rd_outst: +1 on issue, −1 on rd_rsp_valid, unchanged when both occur in the same cycle. It never exceeds MAX_RD_OUTSTANDING and never underflows. A response with rd_outst==0 is ignored.
- Write issue condition: state RUN or DRAIN, wr_issued<lines, wr_line_avail, !c1_alm_full.
  - wr_line_pop=1 in the same cycle the condition holds.
  - wr_req_valid=1 in the next cycle with wr_req_addr = dst + wr_issued (mod 2^CL_ADDR_W).
  - Increment wr_issued.
  - Reads and writes may issue in the same cycle.
- RUN -> DRAIN when rd_issued==lines.
- DRAIN -> DONE when wr_acked==lines and rd_outst==0.
  - wr_acked increments on wr_rsp_valid and saturates at lines.
- DONE: done=1 for exactly one cycle, then IDLE.
- busy=1 in RUN and DRAIN.
- run while busy: the job is unaffected and run_ignored pulses in the following cycle.
- A run arriving in the DONE cycle is honoured as a new job in the next cycle.

Test Plan:
- len=256, src=0x1000, dst=0x2000, no back-pressure, result lines fed after each read response, acks 10 cycles later -> reads to 0x1000..0x1003 with mdata 0..3; writes to 0x2000..0x2003; one done pulse; busy low afterwards.
- len=0 -> no rd_req_valid or wr_req_valid; done pulses exactly 2 cycles after run.
- len=65 -> lines_total=2; exactly 2 reads and 2 writes.
- len=64*200, MAX_RD_OUTSTANDING=64, responses withheld -> exactly 64 reads issued then stall; releasing one response allows exactly one more read.
- c0_alm_full held 20 cycles mid-job, plus buf_full_n low -> zero reads while either is asserted; issue resumes the cycle after both clear.
- src=2^42−2, len=256 -> read addresses 0x3FFFFFFFFFE, 0x3FFFFFFFFFF, 0x0, 0x1.
- Second run pulse during RUN -> run_ignored pulses once and the job completes unchanged.
- reset asserted mid-DRAIN -> all outputs 0 next cycle; no done pulse; a new job afterwards runs normally.

Source files
------------

// File: rtl/mem_copy_job_ctrl.sv
// ---------------------------------------------------------------------------
// mem_copy_job_ctrl
//
// Job sequencer for the generic-processing AFU. It sits between the CSR block
// and the CCI-P/MPF channels and moves one job of cache lines from the source
// to the destination buffer:
//   * a run pulse latches src/dst/length and starts the job;
//   * one c0 read-line request is issued per source line, throttled by c0
//     almost-full, an outstanding-read credit limit and read-buffer space;
//   * one c1 write-line request is issued per processed result line;
//   * done pulses once every read has returned and every write is acked.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   run                         single-cycle start pulse
//   src_cl_addr, dst_cl_addr    first source / destination cache line
//   length_bytes                job length in bytes (rounded up to lines)
//   c0_alm_full                 c0Tx almost-full
//   rd_req_valid/addr/mdata     registered read request (mdata = line index)
//   rd_rsp_valid                one read response line received
//   buf_full_n                  read buffer can take one more line
//   c1_alm_full                 c1Tx almost-full
//   wr_line_avail               a result line is ready
//   wr_line_pop                 consume result line (same cycle as decision)
//   wr_req_valid/addr           registered write request
//   wr_rsp_valid                one write ack received
//   busy                        job in progress (RUN or DRAIN)
//   done                        one-cycle completion pulse
//   run_ignored                 one-cycle pulse: run seen while busy
//   lines_total                 line count of the current / last job
// ---------------------------------------------------------------------------
module mem_copy_job_ctrl #(
    parameter int CL_ADDR_W          = 42,
    parameter int MAX_RD_OUTSTANDING = 64,
    parameter int LEN_W              = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic [CL_ADDR_W-1:0] src_cl_addr,
    input  logic [CL_ADDR_W-1:0] dst_cl_addr,
    input  logic [LEN_W-1:0]     length_bytes,
    input  logic                 c0_alm_full,
    output logic                 rd_req_valid,
    output logic [CL_ADDR_W-1:0] rd_req_addr,
    output logic [15:0]          rd_req_mdata,
    input  logic                 rd_rsp_valid,
    input  logic                 buf_full_n,
    input  logic                 c1_alm_full,
    input  logic                 wr_line_avail,
    output logic                 wr_line_pop,
    output logic                 wr_req_valid,
    output logic [CL_ADDR_W-1:0] wr_req_addr,
    input  logic                 wr_rsp_valid,
    output logic                 busy,
    output logic                 done,
    output logic                 run_ignored,
    output logic [LEN_W-7:0]     lines_total
);

    // Internal line counters carry one extra bit so that a maximal length,
    // which rounds up to exactly 2^(LEN_W-6) lines, still terminates.
    localparam int CNT_W = LEN_W - 5;
    localparam int OUT_W = $clog2(MAX_RD_OUTSTANDING) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t               state;
    logic [CL_ADDR_W-1:0] src_q;
    logic [CL_ADDR_W-1:0] dst_q;
    logic [CNT_W-1:0]     lines_q;
    logic [CNT_W-1:0]     rd_issued;
    logic [CNT_W-1:0]     wr_issued;
    logic [CNT_W-1:0]     wr_acked;
    logic [OUT_W-1:0]     rd_outst;

    // ceil(length_bytes / 64)
    logic [CNT_W-1:0]     lines_in;
    assign lines_in = CNT_W'(length_bytes >> 6) + CNT_W'(|length_bytes[5:0]);

    logic job_active;   // RUN or DRAIN
    logic can_start;    // a run pulse here starts a new job
    logic rd_go;        // issue a read this cycle
    logic wr_go;        // issue a write this cycle
    logic rsp_take;     // read response that actually retires a credit
    logic ack_take;     // write ack that counts toward completion

    assign job_active = (state == RUN) || (state == DRAIN);
    assign can_start  = run && ((state == IDLE) || (state == DONE));

    assign rd_go = (state == RUN)
                && (rd_issued < lines_q)
                && !c0_alm_full
                && (rd_outst < OUT_W'(MAX_RD_OUTSTANDING))
                && buf_full_n;

    assign wr_go = job_active
                && (wr_issued < lines_q)
                && wr_line_avail
                && !c1_alm_full;

    // The pop strobe is combinational; keep it quiet while reset is asserted
    // so an aborting job never swallows a result line.
    assign wr_line_pop = wr_go && !reset;

    // A response with no read outstanding (e.g. stale traffic from an
    // aborted job) must not wrap the credit counter.
    assign rsp_take = rd_rsp_valid && (rd_outst != '0);
    assign ack_take = wr_rsp_valid && job_active && (wr_acked != lines_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            src_q        <= '0;
            dst_q        <= '0;
            lines_q      <= '0;
            rd_issued    <= '0;
            wr_issued    <= '0;
            wr_acked     <= '0;
            rd_outst     <= '0;
            rd_req_valid <= 1'b0;
            rd_req_addr  <= '0;
            rd_req_mdata <= '0;
            wr_req_valid <= 1'b0;
            wr_req_addr  <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            run_ignored  <= 1'b0;
            lines_total  <= '0;
        end else begin
            rd_req_valid <= rd_go;
            wr_req_valid <= wr_go;
            done         <= (state == DONE);
            run_ignored  <= run && job_active;

            if (rd_go) begin
                rd_req_addr  <= src_q + CL_ADDR_W'(rd_issued);
                rd_req_mdata <= rd_issued[15:0];
                rd_issued    <= rd_issued + CNT_W'(1);
            end

            if (wr_go) begin
                wr_req_addr <= dst_q + CL_ADDR_W'(wr_issued);
                wr_issued   <= wr_issued + CNT_W'(1);
            end

            // Issue and retire in the same cycle cancel out.
            if (rd_go && !rsp_take)
                rd_outst <= rd_outst + OUT_W'(1);
            else if (!rd_go && rsp_take)
                rd_outst <= rd_outst - OUT_W'(1);

            if (ack_take)
                wr_acked <= wr_acked + CNT_W'(1);

            case (state)
                IDLE, DONE: begin
                    if (can_start) begin
                        src_q       <= src_cl_addr;
                        dst_q       <= dst_cl_addr;
                        lines_q     <= lines_in;
                        lines_total <= lines_in[LEN_W-7:0];
                        rd_issued   <= '0;
                        wr_issued   <= '0;
                        wr_acked    <= '0;
                        rd_outst    <= '0;
                        // An empty job skips straight to completion.
                        if (lines_in == '0) begin
                            state <= DONE;
                            busy  <= 1'b0;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end

                RUN: begin
                    if (rd_issued == lines_q)
                        state <= DRAIN;
                end

                DRAIN: begin
                    // Wait for the last write ack and for every read to have
                    // come back so no stale response leaks into the next job.
                    if ((wr_acked == lines_q) && (rd_outst == '0)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_copy_job_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for mem_copy_job_ctrl.
// Table of directed jobs plus random jobs, each run cycle by cycle against a
// job-level reference model (counts of reads/responses/writes/acks and a job
// phase), followed by hand-written sequences for the credit limit and for
// reset in the middle of a job.
// ---------------------------------------------------------------------------
module tb_mem_copy_job_ctrl;

    localparam int AW   = 42;
    localparam int MAXO = 64;
    localparam int LW   = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          run;
    logic [AW-1:0] src_cl_addr;
    logic [AW-1:0] dst_cl_addr;
    logic [LW-1:0] length_bytes;
    logic          c0_alm_full;
    logic          rd_req_valid;
    logic [AW-1:0] rd_req_addr;
    logic [15:0]   rd_req_mdata;
    logic          rd_rsp_valid;
    logic          buf_full_n;
    logic          c1_alm_full;
    logic          wr_line_avail;
    logic          wr_line_pop;
    logic          wr_req_valid;
    logic [AW-1:0] wr_req_addr;
    logic          wr_rsp_valid;
    logic          busy;
    logic          done;
    logic          run_ignored;
    logic [LW-7:0] lines_total;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_copy_job_ctrl #(
        .CL_ADDR_W          (AW),
        .MAX_RD_OUTSTANDING (MAXO),
        .LEN_W              (LW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .run           (run),
        .src_cl_addr   (src_cl_addr),
        .dst_cl_addr   (dst_cl_addr),
        .length_bytes  (length_bytes),
        .c0_alm_full   (c0_alm_full),
        .rd_req_valid  (rd_req_valid),
        .rd_req_addr   (rd_req_addr),
        .rd_req_mdata  (rd_req_mdata),
        .rd_rsp_valid  (rd_rsp_valid),
        .buf_full_n    (buf_full_n),
        .c1_alm_full   (c1_alm_full),
        .wr_line_avail (wr_line_avail),
        .wr_line_pop   (wr_line_pop),
        .wr_req_valid  (wr_req_valid),
        .wr_req_addr   (wr_req_addr),
        .wr_rsp_valid  (wr_rsp_valid),
        .busy          (busy),
        .done          (done),
        .run_ignored   (run_ignored),
        .lines_total   (lines_total)
    );

    // bp: 0 = no back-pressure, 1 = random, 2 = scripted c0/buffer stall
    typedef struct {
        logic [63:0]   len;
        logic [AW-1:0] src;
        logic [AW-1:0] dst;
        int            bp;
        int            extra_run;
        longint        exp_lines;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic quiet();
        run           = 1'b0;
        c0_alm_full   = 1'b0;
        rd_rsp_valid  = 1'b0;
        buf_full_n    = 1'b1;
        c1_alm_full   = 1'b0;
        wr_line_avail = 1'b0;
        wr_rsp_valid  = 1'b0;
    endtask

    // Runs one job from an idle DUT and checks every cycle against the model.
    // Model phase: 0 idle, 1 reading, 2 draining, 3 completing.
    task automatic run_job(input logic [63:0] len, input logic [AW-1:0] src,
                           input logic [AW-1:0] dst, input int bp,
                           input int extra_run, input longint exp_lines);
        longint        lines;
        longint        rd_seen, rsp_drv, pops, wr_seen, ack_drv, outst;
        int            ph, ph_n, done_seen, ri_seen, stall_rd, done_cyc;
        bit            exp_rv, exp_wv, exp_done, exp_ri, exp_pop, finished;
        logic [AW-1:0] exp_waddr, a;
        int            ack_q[$];
        lines = longint'((len + 64'd63) / 64'd64);
        rd_seen = 0; rsp_drv = 0; pops = 0; wr_seen = 0; ack_drv = 0; outst = 0;
        ph = 0; done_seen = 0; ri_seen = 0; stall_rd = 0; done_cyc = -1;
        exp_rv = 0; exp_wv = 0; exp_done = 0; exp_ri = 0; finished = 0;
        exp_waddr = '0;
        length_bytes = len;
        src_cl_addr  = src;
        dst_cl_addr  = dst;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            chk("rd_req_valid", rd_req_valid, exp_rv);
            if (rd_req_valid) begin
                a = src + AW'(rd_seen);
                chk("rd_req_addr", rd_req_addr, a);
                chk("rd_req_mdata", rd_req_mdata, rd_seen[15:0]);
                if (bp == 2 && c >= 6 && c <= 30) stall_rd++;
                rd_seen++;
            end
            chk("wr_req_valid", wr_req_valid, exp_wv);
            if (wr_req_valid) begin
                chk("wr_req_addr", wr_req_addr, exp_waddr);
                wr_seen++;
                ack_q.push_back(c + ((bp == 1) ? int'($urandom_range(15)) : 10));
            end
            chk("done", done, exp_done);
            if (done) begin
                done_seen++;
                done_cyc = c;
            end
            chk("busy", busy, (ph == 1 || ph == 2));
            chk("run_ignored", run_ignored, exp_ri);
            if (run_ignored) ri_seen++;
            if (c > 0) chk("lines_total", lines_total, exp_lines);
            if (c > 0 && ph == 0) begin
                finished = 1;
                break;
            end

            // Inputs for this cycle
            run = (c == 0) || (extra_run > 0 && c == extra_run);
            if (bp == 1) begin
                c0_alm_full = ($urandom_range(3) == 0);
                buf_full_n  = ($urandom_range(4) != 0);
                c1_alm_full = ($urandom_range(3) == 0);
            end else if (bp == 2) begin
                c0_alm_full = (c >= 5 && c < 25);
                buf_full_n  = !(c >= 20 && c < 30);
                c1_alm_full = 1'b0;
            end else begin
                c0_alm_full = 1'b0;
                buf_full_n  = 1'b1;
                c1_alm_full = 1'b0;
            end
            outst = rd_seen - rsp_drv;
            rd_rsp_valid  = (outst > 0) && (bp != 1 || $urandom_range(2) == 0);
            wr_line_avail = (rsp_drv > pops) && (bp != 1 || $urandom_range(3) != 0);
            wr_rsp_valid  = 1'b0;
            if (ack_q.size() > 0 && ack_q[0] <= c) begin
                wr_rsp_valid = 1'b1;
                void'(ack_q.pop_front());
            end
            #1;
            exp_pop = (ph == 1 || ph == 2) && pops < lines && wr_line_avail && !c1_alm_full;
            chk("wr_line_pop", wr_line_pop, exp_pop);

            // Expectations for the next cycle
            exp_rv    = (ph == 1) && rd_seen < lines && !c0_alm_full && buf_full_n && outst < MAXO;
            exp_wv    = exp_pop;
            exp_waddr = dst + AW'(pops);
            if (exp_pop) pops++;
            exp_done  = (ph == 3);
            exp_ri    = run && (ph == 1 || ph == 2);
            ph_n = ph;
            case (ph)
                0:       if (run) ph_n = (lines == 0) ? 3 : 1;
                1:       if (rd_seen == lines) ph_n = 2;
                2:       if (ack_drv == lines && outst == 0) ph_n = 3;
                default: ph_n = 0;
            endcase
            ph = ph_n;
            if (rd_rsp_valid) rsp_drv++;
            if (wr_rsp_valid) ack_drv++;
        end
        if (!finished) begin
            n_tests++;
            n_fail++;
            $display("FAIL job_timeout: job len %0d did not finish within cycle budget", len);
        end
        chk("done_count", done_seen, 1);
        chk("rd_count", rd_seen, exp_lines);
        chk("wr_count", wr_seen, exp_lines);
        if (exp_lines == 0) chk("len0_done_cycle", done_cyc, 2);
        if (extra_run > 0) chk("run_ignored_count", ri_seen, 1);
        if (bp == 2) chk("stall_reads", stall_rd, 0);
        quiet();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int       cnt, wcnt, dcnt, bcnt;
        logic [63:0] rlen;
        logic [AW-1:0] rsrc;

        vecs[0] = '{64'd256,        42'h1000,         42'h2000, 0, 0, 4};
        vecs[1] = '{64'd0,          42'h10,           42'h20,   0, 0, 0};
        vecs[2] = '{64'd65,         42'h100,          42'h300,  0, 0, 2};
        vecs[3] = '{64'd256,        42'h3FF_FFFF_FFFE, 42'h500, 0, 0, 4};
        vecs[4] = '{64'd256,        42'h1000,         42'h2000, 0, 3, 4};
        vecs[5] = '{64'd2560,       42'h7000,         42'h9000, 2, 0, 40};
        vecs[6] = '{64'd1,          42'h42,           42'h84,   0, 0, 1};
        vecs[7] = '{64'd639,        42'hABC00,        42'h3FF_FFFF_FFFC, 0, 0, 10};
        vecs[8] = '{64'd832,        42'h5000,         42'h6000, 1, 0, 13};

        // Reset state
        quiet();
        reset = 1'b1;
        length_bytes = '0; src_cl_addr = '0; dst_cl_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rd_req_valid", rd_req_valid, 0);
        chk("reset_wr_req_valid", wr_req_valid, 0);
        chk("reset_wr_line_pop",  wr_line_pop,  0);
        chk("reset_busy",         busy,         0);
        chk("reset_done",         done,         0);
        chk("reset_run_ignored",  run_ignored,  0);
        chk("reset_lines_total",  lines_total,  0);
        reset = 1'b0;

        // Directed job table
        for (int i = 0; i < 9; i++)
            run_job(vecs[i].len, vecs[i].src, vecs[i].dst, vecs[i].bp,
                    vecs[i].extra_run, vecs[i].exp_lines);

        // Random jobs with random back-pressure
        for (int i = 0; i < 6; i++) begin
            rlen = 64'($urandom_range(64 * 30));
            rsrc = (i % 2 == 0) ? AW'({$urandom(), $urandom()})
                                : 42'h3FF_FFFF_FFF0 + AW'($urandom_range(15));
            run_job(rlen, rsrc, AW'({$urandom(), $urandom()}), 1, 0,
                    longint'((rlen + 64'd63) / 64'd64));
        end

        // Credit limit: responses withheld, 200-line job
        quiet();
        length_bytes = 64'd12800; src_cl_addr = 42'h40000; dst_cl_addr = 42'h80000;
        run = 1'b1;
        @(posedge clk); #1;
        run = 1'b0;
        cnt = 0;
        for (int i = 0; i < 150; i++) begin
            @(posedge clk); #1;
            if (rd_req_valid) cnt++;
        end
        chk("credit_limit_reads", cnt, 64);
        chk("credit_limit_busy", busy, 1);
        chk("credit_lines_total", lines_total, 200);
        rd_rsp_valid = 1'b1;
        @(posedge clk); #1;
        rd_rsp_valid = 1'b0;
        cnt = rd_req_valid ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (rd_req_valid) cnt++;
        end
        chk("credit_release_reads", cnt, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_run_busy", busy, 0);
        chk("abort_run_rd_valid", rd_req_valid, 0);

        // Reset while draining (writes outstanding, no acks)
        quiet();
        length_bytes = 64'd256; src_cl_addr = 42'h1000; dst_cl_addr = 42'h2000;
        run = 1'b1;
        @(posedge clk); #1;
        run = 1'b0;
        rd_rsp_valid  = 1'b1;
        wr_line_avail = 1'b1;
        cnt = 0; wcnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (rd_req_valid) cnt++;
            if (wr_req_valid) wcnt++;
        end
        chk("drain_reads", cnt, 4);
        chk("drain_writes", wcnt, 4);
        chk("drain_busy", busy, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_reset_rd_req_valid", rd_req_valid, 0);
        chk("mid_reset_rd_req_addr",  rd_req_addr,  0);
        chk("mid_reset_rd_req_mdata", rd_req_mdata, 0);
        chk("mid_reset_wr_req_valid", wr_req_valid, 0);
        chk("mid_reset_wr_req_addr",  wr_req_addr,  0);
        chk("mid_reset_wr_line_pop",  wr_line_pop,  0);
        chk("mid_reset_busy",         busy,         0);
        chk("mid_reset_done",         done,         0);
        chk("mid_reset_lines_total",  lines_total,  0);
        reset = 1'b0;
        rd_rsp_valid  = 1'b0;
        wr_line_avail = 1'b0;
        dcnt = 0; bcnt = 0;
        for (int i = 0; i < 20; i++) begin
            // stale acks/responses from the aborted job
            wr_rsp_valid = (i < 4);
            rd_rsp_valid = (i < 2);
            @(posedge clk); #1;
            if (done) dcnt++;
            if (busy) bcnt++;
        end
        chk("post_reset_no_done", dcnt, 0);
        chk("post_reset_idle", bcnt, 0);
        quiet();
        run_job(vecs[0].len, vecs[0].src, vecs[0].dst, 0, 0, vecs[0].exp_lines);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
